axi_lite_flash_reader: RTL and testbench

- AXI4-Lite read master that sits directly upstream of the quad-SPI flash slave on the `axi4_lite_if` bus (ADDR_SIZE 24).
- Issues a programmable run of sequential single-beat reads and holds the latest word for the 7-segment/LED display logic.
- Supports continuous (auto) stepping with a configurable inter-read gap, and manual single-stepping.
- Replaces ad-hoc test masters in the FPGA bring-up top.

---
 rtl/axi_lite_pkg.sv | 34 +++
 rtl/axi_lite_flash_reader_if.sv | 26 ++
 rtl/gap_timer.sv | 30 +++
 rtl/axi_lite_flash_reader.sv | 156 +++++++++++++++
 tb/tb_axi_lite_flash_reader.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the flash reader: response codes, reader states, bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_lite_pkg;

  localparam int AXI_ADDR_SIZE = 24;
  localparam int AXI_DATA_SIZE = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_GAP,
    ST_WAIT_STEP
  } rd_state_e;

  // Bits needed to hold max_val (never less than 1).
  function automatic int cnt_width(input int unsigned max_val);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((max_val >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/axi_lite_flash_reader_if.sv
// AXI4-Lite read-only channel bundle (AR + R) between the flash reader and the flash slave.
// Latency: n/a (wires only).
// Backpressure: standard valid/ready on AR and R.
interface axi_lite_flash_reader_if #(
  parameter int ADDR_SIZE = axi_lite_pkg::AXI_ADDR_SIZE,
  parameter int DATA_SIZE = axi_lite_pkg::AXI_DATA_SIZE
);
  logic [ADDR_SIZE-1:0] araddr;
  logic                 arvalid;
  logic [2:0]           arprot;
  logic                 arready;
  logic [DATA_SIZE-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output araddr, arvalid, arprot, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, arprot, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/gap_timer.sv
// Loadable down-counter that flags when it has reached zero; paces reads in auto mode.
// Latency: expired_o rises load_val_i enabled cycles after load_i.
// Backpressure: none; counting pauses while en_i is low.
module gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/axi_lite_flash_reader.sv
// AXI4-Lite read master: runs num_words sequential single-beat reads, holds the latest word.
// Latency: arvalid 1 cycle after start; 2 + GAP_CYCLES cycles per read with a zero-wait slave.
// Backpressure: arvalid/araddr held until arready; rready only in DATA, waits on rvalid.
module axi_lite_flash_reader
  import axi_lite_pkg::*;
#(
  parameter int ADDR_SIZE  = AXI_ADDR_SIZE,
  parameter int DATA_SIZE  = AXI_DATA_SIZE,
  parameter int ADDR_STEP  = 4,
  parameter int GAP_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 auto_mode,
  input  logic                 step,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [CNT_W-1:0]     num_words,
  axi_lite_flash_reader_if.master m_axi,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [ADDR_SIZE-1:0] data_addr,
  output logic                 data_valid,
  output logic [CNT_W-1:0]     words_left,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  rd_state_e            state_q, state_d;
  logic [ADDR_SIZE-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]     words_left_q, words_left_d;
  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic [ADDR_SIZE-1:0] data_addr_q, data_addr_d;
  logic                 data_valid_q, data_valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 gap_load;
  logic                 gap_expired;

  gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .en_i       (state_q == ST_GAP),
    .expired_o  (gap_expired)
  );

  // Next-state and datapath updates; exits from DATA are taken only on the R handshake.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    words_left_d = words_left_q;
    data_out_d   = data_out_q;
    data_addr_d  = data_addr_q;
    data_valid_d = 1'b0;
    done_d       = done_q;
    err_d        = err_q;
    gap_load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_addr_d   = base_addr;
          words_left_d = num_words;
          err_d        = 1'b0;
          // An empty run completes immediately without touching the bus.
          done_d       = (num_words == '0);
          if (num_words != '0) state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // abort is deliberately ignored here: a presented address is never withdrawn.
        if (m_axi.arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (m_axi.rvalid) begin
          data_out_d   = m_axi.rdata;
          data_addr_d  = cur_addr_q;
          data_valid_d = 1'b1;
          words_left_d = words_left_q - 1'b1;
          cur_addr_d   = cur_addr_q + ADDR_SIZE'(ADDR_STEP);
          if (m_axi.rresp != RESP_OKAY) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (words_left_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (abort) begin
            state_d = ST_IDLE;
          end else if (auto_mode) begin
            if (GAP_CYCLES == 0) begin
              state_d = ST_ADDR;
            end else begin
              gap_load = 1'b1;
              state_d  = ST_GAP;
            end
          end else begin
            state_d = ST_WAIT_STEP;
          end
        end
      end
      ST_GAP: begin
        if (abort)            state_d = ST_IDLE;
        else if (gap_expired) state_d = ST_ADDR;
      end
      ST_WAIT_STEP: begin
        if (abort)                  state_d = ST_IDLE;
        else if (step || auto_mode) state_d = ST_ADDR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      words_left_q <= '0;
      data_out_q   <= '0;
      data_addr_q  <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      words_left_q <= words_left_d;
      data_out_q   <= data_out_d;
      data_addr_q  <= data_addr_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Bus controls decode straight from state so reset drops them without waiting for a clock.
  assign m_axi.araddr  = cur_addr_q;
  assign m_axi.arvalid = (state_q == ST_ADDR);
  assign m_axi.arprot  = 3'b000;
  assign m_axi.rready  = (state_q == ST_DATA);

  assign data_out   = data_out_q;
  assign data_addr  = data_addr_q;
  assign data_valid = data_valid_q;
  assign words_left = words_left_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_axi_lite_flash_reader.sv
// Bench for axi_lite_flash_reader: table of auto-mode runs plus directed multi-cycle sequences.
// dut0 uses GAP_CYCLES=0 with a configurable slave; dut1 uses GAP_CYCLES=3 with a zero-wait slave.
// Expected addresses/data are queued when a run is started and popped as the bus/outputs produce them.
module tb_axi_lite_flash_reader;
  import axi_lite_pkg::*;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int CW = 16;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic          ARESETn;
  logic          start, start1, abort, auto_mode, step;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_words;

  axi_lite_flash_reader_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus0 ();
  axi_lite_flash_reader_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus1 ();

  logic [DW-1:0] data_out0, data_out1;
  logic [AW-1:0] data_addr0, data_addr1;
  logic          data_valid0, data_valid1, busy0, busy1, done0, done1, err0, err1;
  logic [CW-1:0] words_left0, words_left1;

  axi_lite_flash_reader #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .ADDR_STEP(4), .GAP_CYCLES(0), .CNT_W(CW)) dut0 (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .abort(abort), .auto_mode(auto_mode), .step(step),
    .base_addr(base_addr), .num_words(num_words), .m_axi(bus0),
    .data_out(data_out0), .data_addr(data_addr0), .data_valid(data_valid0), .words_left(words_left0),
    .busy(busy0), .done(done0), .err(err0));

  axi_lite_flash_reader #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .ADDR_STEP(4), .GAP_CYCLES(3), .CNT_W(CW)) dut1 (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start1), .abort(abort), .auto_mode(auto_mode), .step(step),
    .base_addr(base_addr), .num_words(num_words), .m_axi(bus1),
    .data_out(data_out1), .data_addr(data_addr1), .data_valid(data_valid1), .words_left(words_left1),
    .busy(busy1), .done(done1), .err(err1));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
  endtask

  task automatic fail(input string nm, input string msg);
    checks++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
    return {~a[7:0], a};
  endfunction

  // Slave model / scoreboard state for dut0
  int ar_delay = 0, r_delay = 0, err_idx = -1;
  int ar_cnt = 0, r_cnt = 0, rd_idx = 0;
  int ar_grants = 0, dv_count = 0;
  int cyc0 = 0, last_rise0 = -1;
  bit per_chk0 = 0, prev_arv0 = 0, ar_seen = 0;
  logic [AW-1:0] ar_first = '0, acc_addr = '0;
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] exp_daddr_q[$];
  logic [DW-1:0] exp_data_q[$];

  // dut1 monitor state
  int cyc1 = 0, last_rise1 = -1, dv1_count = 0;
  bit per_chk1 = 0, prev_arv1 = 0;

  initial begin
    bus0.arready = 1'b0; bus0.rvalid = 1'b0; bus0.rdata = '0; bus0.rresp = 2'b00;
    forever begin
      @(negedge ACLK);
      cyc0++;
      if (!ARESETn) begin
        bus0.arready = 1'b0; bus0.rvalid = 1'b0;
        ar_cnt = 0; r_cnt = 0; ar_seen = 0; prev_arv0 = 0;
      end else begin
        if (data_valid0) begin
          dv_count++;
          if (exp_data_q.size() == 0) fail("dv_unexpected", "data_valid with no expected word");
          else begin
            chk("data_out", data_out0, exp_data_q.pop_front());
            chk("data_addr", data_addr0, exp_daddr_q.pop_front());
          end
        end
        if (bus0.arvalid && !prev_arv0) begin
          if (per_chk0 && last_rise0 >= 0) chk("period_b2b", cyc0 - last_rise0, 2);
          last_rise0 = cyc0;
        end
        prev_arv0 = bus0.arvalid;
        // AR channel: a raised arready means the handshake happened on the previous posedge
        if (bus0.arready) begin
          bus0.arready = 1'b0; ar_seen = 0; ar_cnt = 0;
        end else if (bus0.arvalid) begin
          if (!ar_seen) begin ar_seen = 1; ar_first = bus0.araddr; end
          else chk("araddr_stable", bus0.araddr, ar_first);
          if (ar_cnt >= ar_delay) begin
            bus0.arready = 1'b1; ar_grants++; acc_addr = bus0.araddr;
            chk("arprot", bus0.arprot, 3'b000);
            if (exp_addr_q.size() == 0) fail("ar_unexpected", "address issued with none expected");
            else chk("araddr", bus0.araddr, exp_addr_q.pop_front());
          end else ar_cnt++;
        end else if (ar_seen) begin
          fail("arvalid_dropped", "arvalid fell before arready");
          ar_seen = 0;
        end
        // R channel
        if (bus0.rvalid) begin
          bus0.rvalid = 1'b0; r_cnt = 0;
        end else if (bus0.rready) begin
          if (r_cnt >= r_delay) begin
            bus0.rvalid = 1'b1;
            bus0.rdata  = mkdata(acc_addr);
            bus0.rresp  = (rd_idx == err_idx) ? 2'b10 : 2'b00;
            rd_idx++;
          end else r_cnt++;
        end
      end
    end
  end

  initial begin
    bus1.arready = 1'b1; bus1.rvalid = 1'b1; bus1.rdata = 32'h1234_5678; bus1.rresp = 2'b00;
    forever begin
      @(negedge ACLK);
      cyc1++;
      if (!ARESETn) prev_arv1 = 0;
      else begin
        if (data_valid1) dv1_count++;
        if (bus1.arvalid && !prev_arv1) begin
          if (per_chk1 && last_rise1 >= 0) chk("period_gap3", cyc1 - last_rise1, 5);
          last_rise1 = cyc1;
        end
        prev_arv1 = bus1.arvalid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic pulse_start();
    start = 1'b1; @(negedge ACLK); start = 1'b0;
  endtask

  task automatic wait_idle0(input string nm);
    int n = 0;
    while (busy0 && n < 500) begin @(negedge ACLK); n++; end
    if (busy0) fail(nm, "timeout waiting for busy=0");
  endtask

  task automatic push_run(input logic [AW-1:0] base, input int reads);
    logic [AW-1:0] a;
    for (int k = 0; k < reads; k++) begin
      a = base + AW'(4 * k);
      exp_addr_q.push_back(a);
      exp_daddr_q.push_back(a);
      exp_data_q.push_back(mkdata(a));
    end
  endtask

  task automatic new_run(input int ard, input int rdd, input int eidx);
    ar_delay = ard; r_delay = rdd; err_idx = eidx;
    rd_idx = 0; ar_grants = 0; dv_count = 0; last_rise0 = -1;
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [CW-1:0] num;
    int            eidx;
    int            ard;
    int            rdd;
    bit            exp_done;
    bit            exp_err;
    logic [CW-1:0] exp_wl;
    int            exp_reads;
  } vec_t;

  vec_t vecs[6];
  int   n;

  initial begin
    vecs[0] = '{24'h000100, 16'd4, -1, 0, 0, 1'b1, 1'b0, 16'd0, 4};
    vecs[1] = '{24'hFFFFF8, 16'd3, -1, 0, 0, 1'b1, 1'b0, 16'd0, 3};
    vecs[2] = '{24'h000200, 16'd4,  1, 0, 0, 1'b0, 1'b1, 16'd2, 2};
    vecs[3] = '{24'h000300, 16'd2, -1, 2, 3, 1'b1, 1'b0, 16'd0, 2};
    vecs[4] = '{24'h000400, 16'd0, -1, 0, 0, 1'b1, 1'b0, 16'd0, 0};
    vecs[5] = '{24'h000500, 16'd1,  0, 0, 0, 1'b0, 1'b1, 16'd0, 1};

    ARESETn = 1'b0; start = 1'b0; start1 = 1'b0; abort = 1'b0; auto_mode = 1'b0; step = 1'b0;
    base_addr = '0; num_words = '0;
    repeat (3) @(negedge ACLK);
    chk("rst_arvalid", bus0.arvalid, 0);
    chk("rst_rready", bus0.rready, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    chk("rst_data_valid", data_valid0, 0);
    chk("rst_words_left", words_left0, 0);
    chk("rst_data_out", data_out0, 0);
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);

    // Auto-mode runs from the table
    auto_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      new_run(vecs[i].ard, vecs[i].rdd, vecs[i].eidx);
      per_chk0 = (vecs[i].ard == 0 && vecs[i].rdd == 0);
      push_run(vecs[i].base, vecs[i].exp_reads);
      base_addr = vecs[i].base; num_words = vecs[i].num;
      pulse_start();
      chk("first_arvalid", bus0.arvalid, (vecs[i].num != 0));
      chk("busy_after_start", busy0, (vecs[i].num != 0));
      chk("done_after_start", done0, (vecs[i].num == 0));
      wait_idle0("vec_idle");
      repeat (2) @(negedge ACLK);
      chk("vec_done", done0, vecs[i].exp_done);
      chk("vec_err", err0, vecs[i].exp_err);
      chk("vec_words_left", words_left0, vecs[i].exp_wl);
      chk("vec_reads", ar_grants, vecs[i].exp_reads);
      chk("vec_dv_count", dv_count, vecs[i].exp_reads);
      chk("vec_queue_empty", exp_addr_q.size() + exp_data_q.size(), 0);
    end
    per_chk0 = 0;

    // Manual stepping: no second read until step; a step during DATA is ignored
    new_run(0, 3, -1);
    push_run(24'h000600, 3);
    auto_mode = 1'b0; base_addr = 24'h000600; num_words = 16'd3;
    pulse_start();
    n = 0;
    while (dv_count < 1 && n < 100) begin @(negedge ACLK); n++; end
    repeat (4) @(negedge ACLK);
    chk("manual_hold_reads", ar_grants, 1);
    chk("manual_hold_busy", busy0, 1);
    step = 1'b1; @(negedge ACLK); step = 1'b0;
    n = 0;
    while (!bus0.rready && n < 50) begin @(negedge ACLK); n++; end
    step = 1'b1; @(negedge ACLK); step = 1'b0;
    n = 0;
    while (dv_count < 2 && n < 100) begin @(negedge ACLK); n++; end
    repeat (4) @(negedge ACLK);
    chk("step_in_data_ignored", ar_grants, 2);
    step = 1'b1; @(negedge ACLK); step = 1'b0;
    wait_idle0("manual_idle");
    repeat (2) @(negedge ACLK);
    chk("manual_reads", ar_grants, 3);
    chk("manual_done", done0, 1);
    chk("manual_words_left", words_left0, 0);

    // arready stalled 5 cycles, abort raised in cycle 2: read completes, run stops, done=0
    new_run(5, 0, -1);
    push_run(24'h000700, 1);
    auto_mode = 1'b1; base_addr = 24'h000700; num_words = 16'd3;
    pulse_start();
    @(negedge ACLK);
    abort = 1'b1;
    wait_idle0("abort_idle");
    abort = 1'b0;
    repeat (2) @(negedge ACLK);
    chk("abort_reads", ar_grants, 1);
    chk("abort_dv", dv_count, 1);
    chk("abort_done", done0, 0);
    chk("abort_err", err0, 0);
    chk("abort_words_left", words_left0, 2);

    // start while busy is ignored
    new_run(2, 0, -1);
    push_run(24'h000800, 3);
    base_addr = 24'h000800; num_words = 16'd3;
    pulse_start();
    n = 0;
    while (ar_grants < 1 && n < 50) begin @(negedge ACLK); n++; end
    base_addr = 24'h000900; num_words = 16'd7;
    pulse_start();
    wait_idle0("busy_start_idle");
    repeat (2) @(negedge ACLK);
    chk("busy_start_reads", ar_grants, 3);
    chk("busy_start_done", done0, 1);
    chk("busy_start_words_left", words_left0, 0);

    // GAP_CYCLES=3 instance: period 5 cycles, then abort during GAP
    per_chk1 = 1; last_rise1 = -1; dv1_count = 0;
    base_addr = 24'h000A00; num_words = 16'd4;
    start1 = 1'b1; @(negedge ACLK); start1 = 1'b0;
    chk("gap_first_arvalid", bus1.arvalid, 1);
    n = 0;
    while (busy1 && n < 200) begin @(negedge ACLK); n++; end
    repeat (2) @(negedge ACLK);
    chk("gap_done", done1, 1);
    chk("gap_dv_count", dv1_count, 4);
    chk("gap_words_left", words_left1, 0);
    per_chk1 = 0;
    start1 = 1'b1; @(negedge ACLK); start1 = 1'b0;
    n = 0;
    while (!data_valid1 && n < 50) begin @(negedge ACLK); n++; end
    abort = 1'b1;
    @(negedge ACLK);
    chk("gap_abort_busy", busy1, 0);
    chk("gap_abort_done", done1, 0);
    chk("gap_abort_words_left", words_left1, 3);
    abort = 1'b0;

    // Reset in the middle of DATA drops the bus controls at once
    new_run(0, 5, -1);
    push_run(24'h000B00, 1);
    base_addr = 24'h000B00; num_words = 16'd2;
    pulse_start();
    n = 0;
    while (!bus0.rready && n < 50) begin @(negedge ACLK); n++; end
    chk("pre_rst_rready", bus0.rready, 1);
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_arvalid", bus0.arvalid, 0);
    chk("mid_rst_rready", bus0.rready, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_data_valid", data_valid0, 0);
    exp_addr_q.delete(); exp_daddr_q.delete(); exp_data_q.delete();
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("post_rst_done", done0, 0);
    chk("post_rst_words_left", words_left0, 0);
    chk("post_rst_data_out", data_out0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
